// File: rtl/trig_phase_lock.sv
// trig_phase_lock
// Chooses the clk_adc phase/edge on which the other boards' triggers are
// captured cleanly, based on the one-hot sync-phase flags reported at the end
// of each calibration window. It then re-times the coax trigger inputs so that
// the chosen phase lands on frame slot 0.
//
// Ports:
//   clk_adc         in   sole clock, rising edge
//   nrst            in   asynchronous active-low reset
//   cal_window      in   calibration window; its falling edge ends a window
//   phase_ok[7:0]   in   [3:0] rising-edge phases, [7:4] falling-edge phases
//   clear_lock      in   synchronous return to SEARCH, clears error counter
//   trig_in[NCH]    in   raw coax triggers
//   trig_out[NCH]   out  re-timed triggers (blanked 4 cycles on delay change)
//   frame_tick      out  high in frame slot 0 of the 4-cycle frame
//   locked          out  phase lock held (LOCKED or HOLDOVER)
//   sel_phase[1:0]  out  locked phase index
//   sel_edge        out  0 = rising edge, 1 = falling edge
//   lock_err_count  out  bad windows seen while locked, saturating
module trig_phase_lock #(
    parameter int NCH           = 16,
    parameter int LOCK_COUNT    = 3,
    parameter int UNLOCK_MISSES = 2
) (
    input  logic           clk_adc,
    input  logic           nrst,
    input  logic           cal_window,
    input  logic [7:0]     phase_ok,
    input  logic           clear_lock,
    input  logic [NCH-1:0] trig_in,
    output logic [NCH-1:0] trig_out,
    output logic           frame_tick,
    output logic           locked,
    output logic [1:0]     sel_phase,
    output logic           sel_edge,
    output logic [7:0]     lock_err_count
);

    typedef enum logic [1:0] {
        ST_SEARCH   = 2'd0,
        ST_CONFIRM  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_COUNT);
    localparam logic [3:0] MISS_CNT_L = 4'(UNLOCK_MISSES);

    // Exactly one flag set means the window saw a single clean phase.
    function automatic logic f_is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Bit index of the set flag; {edge, phase} falls out of the index directly.
    function automatic logic [2:0] f_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = v[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    state_t         r_state, w_state_next;
    logic [2:0]     r_cand, w_cand_next;
    logic [3:0]     r_match, w_match_next;
    logic [3:0]     r_miss, w_miss_next;
    logic [7:0]     r_err, w_err_next;
    logic [2:0]     r_sel, w_sel_next;
    logic           r_locked;
    logic           r_cal_d;
    logic [1:0]     r_frame;
    logic           r_frame_tick;
    logic [NCH-1:0] r_pipe0, r_pipe1, r_pipe2;
    logic [NCH-1:0] r_trig_out;
    logic [2:0]     r_delay_prev;
    logic [1:0]     r_blank;

    logic           w_win_end;
    logic           w_good;
    logic [2:0]     w_idx;
    logic [2:0]     w_delay;
    logic           w_delay_chg;
    logic [NCH-1:0] w_tap;

    assign w_win_end = r_cal_d & ~cal_window;
    assign w_good    = f_is_onehot(phase_ok);
    assign w_idx     = f_index(phase_ok);

    // Window-edge detector and free-running frame counter with its tick.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            r_cal_d      <= 1'b0;
            r_frame      <= 2'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_cal_d      <= cal_window;
            r_frame      <= r_frame + 2'd1;
            r_frame_tick <= (r_frame == 2'd0);
        end
    end

    // Lock FSM state and the registers it owns.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            r_state  <= ST_SEARCH;
            r_cand   <= 3'd0;
            r_match  <= 4'd0;
            r_miss   <= 4'd0;
            r_err    <= 8'd0;
            r_sel    <= 3'd0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cand   <= w_cand_next;
            r_match  <= w_match_next;
            r_miss   <= w_miss_next;
            r_err    <= w_err_next;
            r_sel    <= w_sel_next;
            r_locked <= (w_state_next == ST_LOCKED) || (w_state_next == ST_HOLDOVER);
        end
    end

    // Lock FSM next-state: window evaluation, with clear_lock taking priority.
    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_match_next = r_match;
        w_miss_next  = r_miss;
        w_err_next   = r_err;
        w_sel_next   = r_sel;
        if (clear_lock) begin
            w_state_next = ST_SEARCH;
            w_match_next = 4'd0;
            w_miss_next  = 4'd0;
            w_err_next   = 8'd0;
        end else if (w_win_end) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_good) begin
                        w_cand_next  = w_idx;
                        w_match_next = 4'd1;
                        if (LOCK_CNT_L == 4'd1) begin
                            w_state_next = ST_LOCKED;
                            w_sel_next   = w_idx;
                            w_miss_next  = 4'd0;
                        end else begin
                            w_state_next = ST_CONFIRM;
                        end
                    end else begin
                        w_state_next = ST_SEARCH;
                    end
                end
                ST_CONFIRM: begin
                    if (w_good && (w_idx == r_cand)) begin
                        w_match_next = r_match + 4'd1;
                        if ((r_match + 4'd1) >= LOCK_CNT_L) begin
                            w_state_next = ST_LOCKED;
                            w_sel_next   = r_cand;
                            w_miss_next  = 4'd0;
                        end else begin
                            w_state_next = ST_CONFIRM;
                        end
                    end else if (w_good) begin
                        w_cand_next  = w_idx;
                        w_match_next = 4'd1;
                    end else begin
                        w_state_next = ST_SEARCH;
                        w_match_next = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_good && (w_idx == r_sel)) begin
                        w_miss_next = 4'd0;
                    end else begin
                        w_err_next = f_sat_inc(r_err);
                        if (MISS_CNT_L == 4'd1) begin
                            w_state_next = ST_SEARCH;
                            w_match_next = 4'd0;
                            w_miss_next  = 4'd0;
                        end else begin
                            w_state_next = ST_HOLDOVER;
                            w_miss_next  = 4'd1;
                        end
                    end
                end
                ST_HOLDOVER: begin
                    if (w_good && (w_idx == r_sel)) begin
                        w_miss_next  = 4'd0;
                        w_state_next = ST_LOCKED;
                    end else begin
                        w_err_next = f_sat_inc(r_err);
                        if ((r_miss + 4'd1) >= MISS_CNT_L) begin
                            w_state_next = ST_SEARCH;
                            w_match_next = 4'd0;
                            w_miss_next  = 4'd0;
                        end else begin
                            w_miss_next = r_miss + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_SEARCH;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Delay 1 + ((4 - phase) mod 4); (0 - phase) in 2 bits is that modulo.
    always_comb begin
        w_delay = 3'd1;
        if (r_locked) begin
            w_delay = 3'd1 + {1'b0, 2'd0 - r_sel[1:0]};
        end else begin
            w_delay = 3'd1;
        end
    end

    assign w_delay_chg = (w_delay != r_delay_prev);

    // Tap select: the output register adds the final cycle of delay.
    always_comb begin
        w_tap = trig_in;
        case (w_delay)
            3'd1:    w_tap = trig_in;
            3'd2:    w_tap = r_pipe0;
            3'd3:    w_tap = r_pipe1;
            3'd4:    w_tap = r_pipe2;
            default: w_tap = trig_in;
        endcase
    end

    // Trigger pipeline and output blanking across delay changes.
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            r_pipe0      <= '0;
            r_pipe1      <= '0;
            r_pipe2      <= '0;
            r_trig_out   <= '0;
            r_delay_prev <= 3'd1;
            r_blank      <= 2'd0;
        end else begin
            r_pipe0      <= trig_in;
            r_pipe1      <= r_pipe0;
            r_pipe2      <= r_pipe1;
            r_delay_prev <= w_delay;
            if (w_delay_chg) begin
                r_trig_out <= '0;
                r_blank    <= 2'd3;
            end else if (r_blank != 2'd0) begin
                r_trig_out <= '0;
                r_blank    <= r_blank - 2'd1;
            end else begin
                r_trig_out <= w_tap;
            end
        end
    end

    assign trig_out       = r_trig_out;
    assign frame_tick     = r_frame_tick;
    assign locked         = r_locked;
    assign sel_phase      = r_sel[1:0];
    assign sel_edge       = r_sel[2];
    assign lock_err_count = r_err;

endmodule

// File: tb/tb_trig_phase_lock.sv
// Directed bench for trig_phase_lock. Expected trig_out pulses are queued
// when a trig_in pulse is driven and popped on the cycle they are due; every
// other cycle trig_out must be zero. Cycle numbers count rising edges since
// nrst release; frame_tick is expected after edges 1, 5, 9, ...
module tb_trig_phase_lock;
    logic        clk_adc = 1'b0;
    logic        nrst;
    logic        cal_window;
    logic [7:0]  phase_ok;
    logic        clear_lock;
    logic [15:0] trig_in;
    logic [15:0] trig_out;
    logic        frame_tick;
    logic        locked;
    logic [1:0]  sel_phase;
    logic        sel_edge;
    logic [7:0]  lock_err_count;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    trig_phase_lock #(.NCH(16), .LOCK_COUNT(3), .UNLOCK_MISSES(2)) dut (
        .clk_adc        (clk_adc),
        .nrst           (nrst),
        .cal_window     (cal_window),
        .phase_ok       (phase_ok),
        .clear_lock     (clear_lock),
        .trig_in        (trig_in),
        .trig_out       (trig_out),
        .frame_tick     (frame_tick),
        .locked         (locked),
        .sel_phase      (sel_phase),
        .sel_edge       (sel_edge),
        .lock_err_count (lock_err_count)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge and check the per-cycle outputs.
    task automatic step();
        logic [15:0] e;
        exp_t        t;
        @(posedge clk_adc);
        #1;
        cyc++;
        e = 16'd0;
        if (sb_q.size() > 0) begin
            if (sb_q[0].due == cyc) begin
                t = sb_q.pop_front();
                e = t.val;
            end
        end
        check("trig_out", 32'(trig_out), 32'(e));
        check("frame_tick", 32'(frame_tick), 32'((cyc % 4) == 1));
    endtask

    // One calibration window; phase_ok is presented on the win_end cycle.
    task automatic win(input logic [7:0] v, input logic clr);
        cal_window = 1'b1;
        repeat (3) step();
        cal_window = 1'b0;
        phase_ok   = v;
        clear_lock = clr;
        step();
        phase_ok   = 8'd0;
        clear_lock = 1'b0;
    endtask

    // Single-cycle trigger pulse; if expected, due d edges after sampling.
    task automatic pulse(input int bitn, input int d, input logic expect_out);
        exp_t t;
        trig_in = 16'd1 << bitn;
        if (expect_out) begin
            t.due = cyc + d;
            t.val = trig_in;
            sb_q.push_back(t);
        end
        step();
        trig_in = 16'd0;
    endtask

    initial begin
        nrst       = 1'b0;
        cal_window = 1'b0;
        phase_ok   = 8'd0;
        clear_lock = 1'b0;
        trig_in    = 16'd0;
        repeat (3) @(posedge clk_adc);
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sel_phase", 32'(sel_phase), 32'd0);
        check("rst_sel_edge", 32'(sel_edge), 32'd0);
        check("rst_err", 32'(lock_err_count), 32'd0);
        check("rst_trig_out", 32'(trig_out), 32'd0);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);
        nrst = 1'b1;
        cyc  = 0;
        repeat (8) step();

        // Unlocked: delay 1
        pulse(3, 1, 1'b1);
        repeat (3) step();

        // Lock acquire on rising phase 2
        win(8'h04, 1'b0);
        check("acq1_locked", 32'(locked), 32'd0);
        win(8'h04, 1'b0);
        check("acq2_locked", 32'(locked), 32'd0);
        win(8'h04, 1'b0);
        check("acq3_locked", 32'(locked), 32'd1);
        check("acq_sel_phase", 32'(sel_phase), 32'd2);
        check("acq_sel_edge", 32'(sel_edge), 32'd0);
        check("acq_err", 32'(lock_err_count), 32'd0);

        // Pulse right after lock lands in the blanking window
        pulse(5, 3, 1'b0);
        repeat (6) step();
        // Re-timed by 3 cycles for phase 2
        pulse(5, 3, 1'b1);
        repeat (5) step();

        // clear_lock wins over a good win_end
        win(8'h04, 1'b1);
        check("clr_locked", 32'(locked), 32'd0);
        check("clr_err", 32'(lock_err_count), 32'd0);
        check("clr_sel_held", 32'(sel_phase), 32'd2);
        win(8'h04, 1'b0);
        check("clr_search_locked", 32'(locked), 32'd0);

        // Candidate change in CONFIRM
        win(8'h01, 1'b0);
        win(8'h01, 1'b0);
        win(8'h20, 1'b0);
        check("cc_w3_locked", 32'(locked), 32'd0);
        win(8'h20, 1'b0);
        check("cc_w4_locked", 32'(locked), 32'd0);
        win(8'h20, 1'b0);
        check("cc_w5_locked", 32'(locked), 32'd1);
        check("cc_sel_phase", 32'(sel_phase), 32'd1);
        check("cc_sel_edge", 32'(sel_edge), 32'd1);
        repeat (6) step();
        // Phase 1 gives a 4-cycle delay
        pulse(2, 4, 1'b1);
        repeat (6) step();

        // Holdover then unlock
        clear_lock = 1'b1;
        step();
        clear_lock = 1'b0;
        check("ho_clr_locked", 32'(locked), 32'd0);
        repeat (3) win(8'h10, 1'b0);
        check("ho_locked", 32'(locked), 32'd1);
        check("ho_sel_phase", 32'(sel_phase), 32'd0);
        check("ho_sel_edge", 32'(sel_edge), 32'd1);
        win(8'h00, 1'b0);
        check("ho_bad1_locked", 32'(locked), 32'd1);
        check("ho_bad1_err", 32'(lock_err_count), 32'd1);
        win(8'h03, 1'b0);
        check("ho_bad2_locked", 32'(locked), 32'd0);
        check("ho_bad2_err", 32'(lock_err_count), 32'd2);

        // Recovery from holdover
        clear_lock = 1'b1;
        step();
        clear_lock = 1'b0;
        check("rc_clr_err", 32'(lock_err_count), 32'd0);
        repeat (3) win(8'h10, 1'b0);
        check("rc_locked", 32'(locked), 32'd1);
        win(8'h00, 1'b0);
        check("rc_bad_locked", 32'(locked), 32'd1);
        win(8'h10, 1'b0);
        check("rc_good_locked", 32'(locked), 32'd1);
        check("rc_err", 32'(lock_err_count), 32'd1);
        // Locked on phase 0: delay stays 1, no blanking on that lock
        pulse(7, 1, 1'b1);
        repeat (2) step();

        // cal_window stuck high: no evaluation
        cal_window = 1'b1;
        repeat (8) step();
        check("stuck_locked", 32'(locked), 32'd1);
        check("stuck_err", 32'(lock_err_count), 32'd1);
        cal_window = 1'b0;
        phase_ok   = 8'h10;
        step();
        phase_ok   = 8'd0;
        check("stuck_end_err", 32'(lock_err_count), 32'd1);
        check("stuck_end_locked", 32'(locked), 32'd1);

        // Asynchronous reset mid-operation
        @(posedge clk_adc);
        #3;
        nrst = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_err", 32'(lock_err_count), 32'd0);
        check("arst_sel_phase", 32'(sel_phase), 32'd0);
        check("arst_sel_edge", 32'(sel_edge), 32'd0);
        check("arst_trig_out", 32'(trig_out), 32'd0);
        check("arst_frame_tick", 32'(frame_tick), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/trig_phase_lock.md
Name: trig_phase_lock

Overview:
- Consumes the per-window sync-phase flags from the trigger sync/phase-detect stage on the trigger board.
- Decides which of the 4 clk_adc phases, and which clock edge, captures the other boards' triggers cleanly.
- Requires several consecutive agreeing calibration windows before declaring lock.
- Re-times the 16 coax trigger inputs so the chosen phase lands on frame slot 0, then hands aligned triggers and lock status to the trigger logic downstream.

Parameters:
- NCH, 16: number of trigger channels re-timed.
- LOCK_COUNT, 3: consecutive identical single-hot windows required to lock (range 1-15).
- UNLOCK_MISSES, 2: consecutive bad windows while locked before lock is dropped (range 1-15).

Ports:
- clk_adc  in  1  sole clock; all logic on its rising edge.
- nrst  in  1  asynchronous, active-low reset.
- cal_window  in  1  high while the upstream stage is counting sync pulses; its falling edge ends a window.
- phase_ok  in  8  upstream flags; bits 0-3 are rising-edge phases 0-3, bits 4-7 are falling-edge phases 0-3.
- clear_lock  in  1  synchronous request: return to SEARCH and clear the error counter.
- trig_in  in  NCH  raw coax trigger inputs.
- trig_out  out  NCH  trig_in re-timed to the locked phase.
- frame_tick  out  1  high in frame slot 0 of the free-running 4-cycle frame.
- locked  out  1  phase lock held.
- sel_phase  out  2  locked phase index.
- sel_edge  out  1  0 = rising edge won, 1 = falling edge won.
- lock_err_count  out  8  bad windows seen while locked; saturates at 255.

Behaviour:
- Reset values: all outputs 0; state SEARCH; candidate 0; match count 0; miss count 0; frame counter 0.
- Frame counter: 2-bit, free-running, increments every cycle from reset. It shares nrst with the upstream pulse counter, so the two stay aligned. frame_tick = (frame counter == 0), registered.
- Window end (win_end): cal_window registered once into cal_d; win_end = cal_d & ~cal_window. Evaluation uses phase_ok on the win_end cycle; state updates on the next edge.
- Snapshot classification: good if exactly one of the 8 bits is set, giving cand = {edge = bit index ≥ 4, phase = index mod 4}. Zero or more than one bit set is bad.
- SEARCH:
  - good win_end: load candidate, match = 1; go CONFIRM, or straight to LOCKED if LOCK_COUNT == 1.
  - bad win_end: stay in SEARCH.
- CONFIRM:
  - good win_end with same cand: match + 1; on reaching LOCK_COUNT go LOCKED and latch sel_phase/sel_edge.
  - good win_end with different cand: reload candidate, match = 1.
  - bad win_end: go SEARCH, match = 0.
- LOCKED:
  - locked = 1.
  - good win_end with same cand: misses = 0.
  - good win_end with different cand, or bad win_end: lock_err_count + 1 (saturating); go HOLDOVER, misses = 1.
- HOLDOVER:
  - locked stays 1 and sel_* are unchanged.
  - good win_end with the locked cand: misses = 0, go LOCKED.
  - other win_end: lock_err_count + 1, misses + 1; when misses reaches UNLOCK_MISSES, go SEARCH with locked = 0. If UNLOCK_MISSES == 1, the first bad window goes directly from LOCKED to SEARCH.
- clear_lock: takes priority over win_end in the same cycle. Next state is SEARCH; match, misses and lock_err_count are cleared; locked = 0; sel_* are held.
- Re-timing:
  - trig_in passes through a pipeline of delay D = 1 + ((4 - sel_phase) mod 4) cycles, i.e. D is 1, 4, 3, 2 for phase 0, 1, 2, 3.
  - When unlocked, D = 1.
  - sel_edge does not affect the delay (reported only).
- Delay change: any cycle where the effective D changes (lock gained, lock lost, or relock to a new phase) forces trig_out = 0 for the next 4 cycles, so no trigger is duplicated or dropped mid-switch.
- Mid-window: cal_window rising has no effect. A window with no falling edge (cal_window stuck high) simply produces no evaluation.
- Asynchronous reset mid-operation: state and outputs return to reset values immediately; the pipeline is cleared.

Test Plan:
- Reset and frame: release nrst, drive trig_in = 0 -> all outputs 0; frame_tick high on cycles 0, 4, 8 after release.
- Lock acquire: 3 windows with phase_ok = 8'h04 at each win_end -> locked rises 1 cycle after the 3rd win_end; sel_phase = 2, sel_edge = 0.
- Re-timing: while locked on phase 2 with the blanking window over, a single-cycle pulse on trig_in[5] -> trig_out[5] pulses exactly 3 cycles later.
- Blanking: the first trig_in pulse applied within 4 cycles of lock rising produces no trig_out output.
- Candidate change in CONFIRM: windows 8'h01, 8'h01, 8'h20, 8'h20, 8'h20 -> lock on phase 1, edge 1 after window 5, not earlier.
- Holdover and unlock: locked on 8'h10, then windows 8'h00 and 8'h03 -> lock_err_count = 2, locked falls after the 2nd bad window.
- Recovery variant: locked on 8'h10, then windows 8'h00 and 8'h10 -> locked never falls, lock_err_count = 1.
- clear_lock priority: assert clear_lock on the same cycle as a good win_end while locked -> state SEARCH, lock_err_count = 0, locked = 0 next cycle.
